bp_cfg_boot_sequencer: RTL and testbench

Sequences the power-on configuration of one BlackParrot tile over the config link. On a start pulse it freezes the core and writes every per-tile config register: core/icache/dcache/cce ids, cache and CCE modes, LCE count and start PC. It then streams the CCE microcode from a synchronous ROM into the ucode window and unfreezes the core. It sits between the chip-level boot logic and the tile's config-link slave, which is the only consumer of its write stream.

---
 rtl/bp_cfg_boot_sequencer_pkg.sv | 36 +++
 rtl/bp_cfg_boot_reg_rom.sv | 51 +++++
 rtl/bp_cfg_boot_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_bp_cfg_boot_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_boot_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bp_cfg_boot_sequencer_pkg
// Shared config-link definitions for the tile boot sequencer: the sequencer
// state encoding and the per-tile config register addresses.
// No ports (package). Optional feature macro: BP_CFG_BOOT_UCODE_EN.
// -----------------------------------------------------------------------------
package bp_cfg_boot_sequencer_pkg;

    // Sequencer state encoding, kept as plain constants for legacy tools
    typedef logic [2:0] boot_state_t;

    localparam boot_state_t state_idle     = 3'd0;
    localparam boot_state_t state_freeze   = 3'd1;
    localparam boot_state_t state_regs     = 3'd2;
    localparam boot_state_t state_ucode_rd = 3'd3;
    localparam boot_state_t state_ucode_wr = 3'd4;
    localparam boot_state_t state_unfreeze = 3'd5;
    localparam boot_state_t state_done     = 3'd6;

    // Config-link register map of one tile
    localparam logic [15:0] cfg_addr_freeze      = 16'h0002;
    localparam logic [15:0] cfg_addr_core_id     = 16'h0003;
    localparam logic [15:0] cfg_addr_icache_id   = 16'h0021;
    localparam logic [15:0] cfg_addr_icache_mode = 16'h0022;
    localparam logic [15:0] cfg_addr_start_pc    = 16'h0040;
    localparam logic [15:0] cfg_addr_dcache_id   = 16'h0041;
    localparam logic [15:0] cfg_addr_dcache_mode = 16'h0042;
    localparam logic [15:0] cfg_addr_cce_id      = 16'h0060;
    localparam logic [15:0] cfg_addr_cce_mode    = 16'h0061;
    localparam logic [15:0] cfg_addr_num_lce     = 16'h0062;
    localparam logic [15:0] cfg_addr_ucode_base  = 16'h8000;

    // Index of the last register in the REGS phase (nine writes)
    localparam logic [3:0] reg_last_idx = 4'd8;

endpackage

// File: rtl/bp_cfg_boot_reg_rom.sv
// -----------------------------------------------------------------------------
// bp_cfg_boot_reg_rom
// Maps the REGS-phase index onto the config register address and the
// zero-extended write data taken from the captured configuration values.
// Ports:
//   idx                 in   4-bit REGS index (0..8)
//   core_id             in   captured tile id (also icache/dcache/cce id)
//   icache_mode, dcache_mode, cce_mode  in  captured 2-bit modes
//   num_lce             in   captured LCE count
//   start_pc            in   captured 39-bit boot PC
//   reg_addr            out  config register address
//   reg_data            out  zero-extended write data
// Optional feature macro: BP_CFG_BOOT_UCODE_EN (not used in this file).
// -----------------------------------------------------------------------------
module bp_cfg_boot_reg_rom
    import bp_cfg_boot_sequencer_pkg::*;
#(
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int core_id_width_p  = 8
) (
    input  logic [3:0]                  idx,
    input  logic [core_id_width_p-1:0]  core_id,
    input  logic [1:0]                  icache_mode,
    input  logic [1:0]                  dcache_mode,
    input  logic [1:0]                  cce_mode,
    input  logic [7:0]                  num_lce,
    input  logic [38:0]                 start_pc,
    output logic [cfg_addr_width_p-1:0] reg_addr,
    output logic [cfg_data_width_p-1:0] reg_data
);

    // Fixed write order of the REGS phase; out-of-range indices map to zero
    always_comb begin
        reg_addr = '0;
        reg_data = '0;
        case (idx)
            4'd0: begin reg_addr = cfg_addr_width_p'(cfg_addr_core_id);     reg_data = cfg_data_width_p'(core_id);     end
            4'd1: begin reg_addr = cfg_addr_width_p'(cfg_addr_icache_id);   reg_data = cfg_data_width_p'(core_id);     end
            4'd2: begin reg_addr = cfg_addr_width_p'(cfg_addr_icache_mode); reg_data = cfg_data_width_p'(icache_mode); end
            4'd3: begin reg_addr = cfg_addr_width_p'(cfg_addr_start_pc);    reg_data = cfg_data_width_p'(start_pc);    end
            4'd4: begin reg_addr = cfg_addr_width_p'(cfg_addr_dcache_id);   reg_data = cfg_data_width_p'(core_id);     end
            4'd5: begin reg_addr = cfg_addr_width_p'(cfg_addr_dcache_mode); reg_data = cfg_data_width_p'(dcache_mode); end
            4'd6: begin reg_addr = cfg_addr_width_p'(cfg_addr_cce_id);      reg_data = cfg_data_width_p'(core_id);     end
            4'd7: begin reg_addr = cfg_addr_width_p'(cfg_addr_cce_mode);    reg_data = cfg_data_width_p'(cce_mode);    end
            4'd8: begin reg_addr = cfg_addr_width_p'(cfg_addr_num_lce);     reg_data = cfg_data_width_p'(num_lce);     end
            default: ;
        endcase
    end

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// -----------------------------------------------------------------------------
// bp_cfg_boot_sequencer
// Power-on configuration sequencer for one tile: freezes the core, writes the
// per-tile config registers, optionally streams CCE microcode from a
// synchronous ROM into the ucode window, then unfreezes the core.
// Optional feature macro: BP_CFG_BOOT_UCODE_EN enables the ucode phase; when
// undefined the ROM port is tied off and REGS goes straight to UNFREEZE.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i             one-cycle start request (honoured in IDLE/DONE)
//   core_id_i, icache_mode_i, dcache_mode_i, cce_mode_i, num_lce_i,
//   start_pc_i          configuration values, captured at start
//   cfg_v_o / cfg_ready_i / cfg_addr_o / cfg_data_o   config-link write port
//   ucode_addr_o / ucode_r_v_o / ucode_data_i         ucode ROM read port
//   busy_o, done_o      sequence status
// -----------------------------------------------------------------------------
module bp_cfg_boot_sequencer
    import bp_cfg_boot_sequencer_pkg::*;
#(
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int core_id_width_p  = 8,
    parameter int ucode_entries_p  = 256,
    parameter int ucode_width_p    = 64,
    localparam int ucode_addr_width_lp = $clog2(ucode_entries_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic [core_id_width_p-1:0]     core_id_i,
    input  logic [1:0]                     icache_mode_i,
    input  logic [1:0]                     dcache_mode_i,
    input  logic [1:0]                     cce_mode_i,
    input  logic [7:0]                     num_lce_i,
    input  logic [38:0]                    start_pc_i,
    output logic                           cfg_v_o,
    input  logic                           cfg_ready_i,
    output logic [cfg_addr_width_p-1:0]    cfg_addr_o,
    output logic [cfg_data_width_p-1:0]    cfg_data_o,
    output logic [ucode_addr_width_lp-1:0] ucode_addr_o,
    output logic                           ucode_r_v_o,
    input  logic [ucode_width_p-1:0]       ucode_data_i,
    output logic                           busy_o,
    output logic                           done_o
);

    boot_state_t                  state_r;
    logic [3:0]                   reg_idx_r;
    logic [core_id_width_p-1:0]   core_id_r;
    logic [1:0]                   icache_mode_r;
    logic [1:0]                   dcache_mode_r;
    logic [1:0]                   cce_mode_r;
    logic [7:0]                   num_lce_r;
    logic [38:0]                  start_pc_r;
    logic [cfg_addr_width_p-1:0]  reg_addr;
    logic [cfg_data_width_p-1:0]  reg_data;
    logic                         start_ok;

`ifdef BP_CFG_BOOT_UCODE_EN
    localparam logic [ucode_addr_width_lp-1:0] ucode_last_idx = ucode_addr_width_lp'(ucode_entries_p - 1);

    logic [ucode_addr_width_lp-1:0] ucode_idx_r;
    logic [ucode_width_p-1:0]       ucode_hold_r;
    // High only in the first UCODE_WR cycle, when the ROM output is fresh
    logic                           ucode_first_r;
`else
    logic ucode_data_unused;
    assign ucode_data_unused = ^ucode_data_i;
`endif

    assign start_ok = start_i && ((state_r == state_idle) || (state_r == state_done));
    assign busy_o   = (state_r != state_idle) && (state_r != state_done);
    assign done_o   = (state_r == state_done);

    bp_cfg_boot_reg_rom #(
        .cfg_addr_width_p (cfg_addr_width_p),
        .cfg_data_width_p (cfg_data_width_p),
        .core_id_width_p  (core_id_width_p)
    ) reg_rom (
        .idx         (reg_idx_r),
        .core_id     (core_id_r),
        .icache_mode (icache_mode_r),
        .dcache_mode (dcache_mode_r),
        .cce_mode    (cce_mode_r),
        .num_lce     (num_lce_r),
        .start_pc    (start_pc_r),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data)
    );

    // Main sequencer: captures the configuration on an accepted start and
    // only advances a write state when the slave accepts the current write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= state_idle;
            reg_idx_r     <= '0;
            core_id_r     <= '0;
            icache_mode_r <= '0;
            dcache_mode_r <= '0;
            cce_mode_r    <= '0;
            num_lce_r     <= '0;
            start_pc_r    <= '0;
`ifdef BP_CFG_BOOT_UCODE_EN
            ucode_idx_r   <= '0;
            ucode_hold_r  <= '0;
            ucode_first_r <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                core_id_r     <= core_id_i;
                icache_mode_r <= icache_mode_i;
                dcache_mode_r <= dcache_mode_i;
                cce_mode_r    <= cce_mode_i;
                num_lce_r     <= num_lce_i;
                start_pc_r    <= start_pc_i;
            end
            case (state_r)
                state_idle, state_done: begin
                    if (start_ok) begin
                        state_r   <= state_freeze;
                        reg_idx_r <= '0;
`ifdef BP_CFG_BOOT_UCODE_EN
                        ucode_idx_r <= '0;
`endif
                    end
                end
                state_freeze: begin
                    if (cfg_ready_i) state_r <= state_regs;
                end
                state_regs: begin
                    if (cfg_ready_i) begin
                        if (reg_idx_r == reg_last_idx) begin
                            reg_idx_r <= '0;
`ifdef BP_CFG_BOOT_UCODE_EN
                            state_r   <= state_ucode_rd;
`else
                            state_r   <= state_unfreeze;
`endif
                        end else begin
                            reg_idx_r <= reg_idx_r + 4'd1;
                        end
                    end
                end
`ifdef BP_CFG_BOOT_UCODE_EN
                state_ucode_rd: begin
                    state_r       <= state_ucode_wr;
                    ucode_first_r <= 1'b1;
                end
                state_ucode_wr: begin
                    // ROM data is only guaranteed in the cycle after the read,
                    // so it is latched then and replayed during any stall.
                    ucode_first_r <= 1'b0;
                    if (ucode_first_r) ucode_hold_r <= ucode_data_i;
                    if (cfg_ready_i) begin
                        if (ucode_idx_r == ucode_last_idx) begin
                            state_r <= state_unfreeze;
                        end else begin
                            ucode_idx_r <= ucode_idx_r + ucode_addr_width_lp'(1);
                            state_r     <= state_ucode_rd;
                        end
                    end
                end
`endif
                state_unfreeze: begin
                    if (cfg_ready_i) state_r <= state_done;
                end
                default: state_r <= state_idle;
            endcase
        end
    end

    // Write port is decoded purely from state, so address and data stay
    // stable for as long as the state is stalled waiting for ready.
    always_comb begin
        cfg_v_o     = 1'b0;
        cfg_addr_o  = '0;
        cfg_data_o  = '0;
        ucode_r_v_o = 1'b0;
        case (state_r)
            state_freeze: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_freeze);
                cfg_data_o = cfg_data_width_p'(1);
            end
            state_regs: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = reg_addr;
                cfg_data_o = reg_data;
            end
`ifdef BP_CFG_BOOT_UCODE_EN
            state_ucode_rd: begin
                ucode_r_v_o = 1'b1;
            end
            state_ucode_wr: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_ucode_base) + cfg_addr_width_p'(ucode_idx_r);
                cfg_data_o = cfg_data_width_p'(ucode_first_r ? ucode_data_i : ucode_hold_r);
            end
`endif
            state_unfreeze: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_freeze);
                cfg_data_o = '0;
            end
            default: ;
        endcase
    end

`ifdef BP_CFG_BOOT_UCODE_EN
    assign ucode_addr_o = ucode_idx_r;
`else
    assign ucode_addr_o = '0;
`endif

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bp_cfg_boot_sequencer
// Directed bench for bp_cfg_boot_sequencer with a 4-entry ucode ROM model.
// Works with or without BP_CFG_BOOT_UCODE_EN defined.
// -----------------------------------------------------------------------------
module tb_bp_cfg_boot_sequencer;

    localparam int N     = 4;
    localparam int UA_W  = $clog2(N);
`ifdef BP_CFG_BOOT_UCODE_EN
    localparam int LAT   = 1 + 9 + 2 * N + 1 + 1;
    localparam int EXPRV = N;
`else
    localparam int LAT   = 12;
    localparam int EXPRV = 0;
`endif

    logic        clk;
    logic        reset_i;
    logic        start_i;
    logic [7:0]  core_id_i;
    logic [1:0]  icache_mode_i, dcache_mode_i, cce_mode_i;
    logic [7:0]  num_lce_i;
    logic [38:0] start_pc_i;
    logic        cfg_v_o;
    logic        cfg_ready_i;
    logic [15:0] cfg_addr_o;
    logic [63:0] cfg_data_o;
    logic [UA_W-1:0] ucode_addr_o;
    logic        ucode_r_v_o;
    logic [63:0] ucode_data_i;
    logic        busy_o, done_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr [16];
    logic [63:0] exp_data [16];
    int          exp_len;
    logic        mon_en = 1'b0;
    int          mon_ptr;
    int          mon_stalls;
    int          mon_rv;

    bp_cfg_boot_sequencer #(
        .cfg_addr_width_p (16),
        .cfg_data_width_p (64),
        .core_id_width_p  (8),
        .ucode_entries_p  (N),
        .ucode_width_p    (64)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .core_id_i     (core_id_i),
        .icache_mode_i (icache_mode_i),
        .dcache_mode_i (dcache_mode_i),
        .cce_mode_i    (cce_mode_i),
        .num_lce_i     (num_lce_i),
        .start_pc_i    (start_pc_i),
        .cfg_v_o       (cfg_v_o),
        .cfg_ready_i   (cfg_ready_i),
        .cfg_addr_o    (cfg_addr_o),
        .cfg_data_o    (cfg_data_o),
        .ucode_addr_o  (ucode_addr_o),
        .ucode_r_v_o   (ucode_r_v_o),
        .ucode_data_i  (ucode_data_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] romWord(input int k);
        return 64'hC0DE_0000_0000_0000 | (64'h1111 * 64'(k + 1));
    endfunction

    // Synchronous ROM model: data appears the cycle after the read enable
    initial ucode_data_i = '0;
    always @(posedge clk) begin
        if (ucode_r_v_o) ucode_data_i <= romWord(int'(ucode_addr_o));
    end

    // Write monitor: every valid cycle must show the next expected write,
    // including every stalled cycle, and each read address must count up.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cfg_v_o) begin
                int p;
                p = (mon_ptr < 16) ? mon_ptr : 15;
                checks++;
                assert (mon_ptr < exp_len && cfg_addr_o === exp_addr[p] && cfg_data_o === exp_data[p])
                else begin
                    errors++;
                    $error("[TB] FAIL write_stream idx %0d observed %h/%h expected %h/%h",
                           mon_ptr, cfg_addr_o, cfg_data_o, exp_addr[p], exp_data[p]);
                end
                if (cfg_ready_i) mon_ptr++;
                else mon_stalls++;
            end
            if (ucode_r_v_o) begin
                checks++;
                assert (ucode_addr_o === UA_W'(mon_rv))
                else begin
                    errors++;
                    $error("[TB] FAIL ucode_addr observed %0d expected %0d", ucode_addr_o, mon_rv);
                end
                mon_rv++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input logic [15:0] a, input logic [63:0] d);
        exp_addr[exp_len] = a;
        exp_data[exp_len] = d;
        exp_len++;
    endtask

    // Hand-written register map with fixed modes 1/2/3, 4 LCEs, PC 0x80000000
    task automatic buildExpected(input logic [7:0] id);
        exp_len = 0;
        pushExp(16'h0002, 64'd1);
        pushExp(16'h0003, {56'd0, id});
        pushExp(16'h0021, {56'd0, id});
        pushExp(16'h0022, 64'd1);
        pushExp(16'h0040, 64'h8000_0000);
        pushExp(16'h0041, {56'd0, id});
        pushExp(16'h0042, 64'd2);
        pushExp(16'h0060, {56'd0, id});
        pushExp(16'h0061, 64'd3);
        pushExp(16'h0062, 64'd4);
`ifdef BP_CFG_BOOT_UCODE_EN
        for (int k = 0; k < N; k++) pushExp(16'h8000 + 16'(k), romWord(k));
`endif
        pushExp(16'h0002, 64'd0);
    endtask

    // Runs one full sequence from a start pulse to done_o; optional random
    // stalls and an ignored start pulse with a different id at cycle pulseAt.
    task automatic applyStimulus(input logic [7:0] id, input bit stall, input int pulseAt, input logic [7:0] altId);
        int cyc;
        buildExpected(id);
        mon_ptr    = 0;
        mon_stalls = 0;
        mon_rv     = 0;
        mon_en     = 1'b1;
        core_id_i  = id;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 1;
        checkOutput("cfg_v_cycle1", 64'(cfg_v_o), 64'd1);
        checkOutput("busy_cycle1", 64'(busy_o), 64'd1);
        checkOutput("done_cleared_cycle1", 64'(done_o), 64'd0);
        while (!done_o && cyc < 400) begin
            cfg_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i = (cyc == pulseAt);
            if (cyc == pulseAt) core_id_i = altId;
            @(posedge clk); #1;
            start_i = 1'b0;
            cyc++;
        end
        cfg_ready_i = 1'b1;
        checkOutput("latency", 64'(cyc), 64'(LAT + mon_stalls));
        checkOutput("stream_len", 64'(mon_ptr), 64'(exp_len));
        checkOutput("ucode_reads", 64'(mon_rv), 64'(EXPRV));
        checkOutput("busy_at_done", 64'(busy_o), 64'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        int cyc;
        reset_i       = 1'b1;
        start_i       = 1'b0;
        core_id_i     = 8'd0;
        icache_mode_i = 2'd1;
        dcache_mode_i = 2'd2;
        cce_mode_i    = 2'd3;
        num_lce_i     = 8'd4;
        start_pc_i    = 39'h80000000;
        cfg_ready_i   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_cfg_v", 64'(cfg_v_o), 64'd0);
        checkOutput("reset_cfg_addr", 64'(cfg_addr_o), 64'd0);
        checkOutput("reset_cfg_data", cfg_data_o, 64'd0);
        checkOutput("reset_ucode_r_v", 64'(ucode_r_v_o), 64'd0);
        checkOutput("reset_ucode_addr", 64'(ucode_addr_o), 64'd0);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_done", 64'(done_o), 64'd0);
        reset_i = 1'b0;
        @(posedge clk); #1;

        $display("[TB] baseline sequence, ready high, core_id 5");
        applyStimulus(8'd5, 1'b0, 0, 8'd0);

        $display("[TB] restart from DONE, random stalls, ignored mid start");
        applyStimulus(8'd7, 1'b1, 4, 8'd9);

        $display("[TB] reset mid-sequence then replay");
        buildExpected(8'd3);
        mon_ptr = 0; mon_stalls = 0; mon_rv = 0; mon_en = 1'b1;
        core_id_i = 8'd3;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
`ifdef BP_CFG_BOOT_UCODE_EN
        while (!(cfg_v_o && cfg_addr_o === 16'h8001) && cyc < 100) begin
`else
        while (!(cfg_v_o && cfg_addr_o === 16'h0041) && cyc < 100) begin
`endif
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("abort_point_reached", 64'(cyc < 100), 64'd1);
        mon_en  = 1'b0;
        reset_i = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_cfg_v", 64'(cfg_v_o), 64'd0);
        checkOutput("abort_busy", 64'(busy_o), 64'd0);
        checkOutput("abort_done", 64'(done_o), 64'd0);
        checkOutput("abort_ucode_r_v", 64'(ucode_r_v_o), 64'd0);
        reset_i = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'd3, 1'b0, 0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
